// File: rtl/half_band_decimator_2_if.sv
// rtl/half_band_decimator_2_if.sv - sample-in / decimated-sample-out bundle for the second half-band stage
interface half_band_decimator_2_if;
  logic               clk_en;
  logic signed [17:0] x_in;
  logic signed [17:0] y;
  logic               y_en;
  logic               overrun;

  modport master (output clk_en, x_in, input y, y_en, overrun);
  modport slave  (input clk_en, x_in, output y, y_en, overrun);
endinterface

// File: rtl/half_band_decimator_2.sv
// rtl/half_band_decimator_2.sv - 11-tap half-band decimate-by-2 FIR, one shared multiplier
// Odd taps are zero and the centre tap is 0.5, so only three multiplies per output are needed.
module half_band_decimator_2 (
  input  logic                    clk,
  input  logic                    reset,
  half_band_decimator_2_if.slave  bus
);
  localparam logic signed [17:0] COEF0 = 18'sd1730;
  localparam logic signed [17:0] COEF1 = -18'sd13369;
  localparam logic signed [17:0] COEF2 = 18'sd77175;

  typedef enum logic [2:0] {S_IDLE, S_M0, S_M1, S_M2, S_FIN} state_t;

  state_t             r_state;
  state_t             w_next;
  logic signed [17:0] r_x [0:10];
  logic               r_phase;
  logic signed [36:0] r_prod;
  logic signed [18:0] r_s1;
  logic signed [18:0] r_s2;
  logic signed [17:0] r_c;
  logic signed [39:0] r_acc;
  logic signed [17:0] r_y;
  logic               r_y_en;
  logic               r_overrun;

  logic               w_trig;
  logic               w_busy;
  logic signed [18:0] w_mul_a;
  logic signed [17:0] w_mul_b;
  logic signed [36:0] w_prod;
  logic signed [39:0] w_prod_ext;
  logic signed [39:0] w_c_ext;
  logic signed [39:0] w_acc_fin;
  logic signed [39:0] w_shift;
  logic signed [17:0] w_y_sat;

  assign w_trig = bus.clk_en & r_phase;
  assign w_busy = (r_state == S_M0) || (r_state == S_M1) || (r_state == S_M2);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_trig) w_next = S_M0;
      S_M0:    w_next = S_M1;
      S_M1:    w_next = S_M2;
      S_M2:    w_next = S_FIN;
      S_FIN:   w_next = w_trig ? S_M0 : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The single multiplier: operands are steered by the current FSM step.
  always_comb begin
    w_mul_a = '0;
    w_mul_b = '0;
    case (r_state)
      S_M0: begin
        w_mul_a = 19'(r_x[0]) + 19'(r_x[10]);
        w_mul_b = COEF0;
      end
      S_M1: begin
        w_mul_a = r_s1;
        w_mul_b = COEF1;
      end
      S_M2: begin
        w_mul_a = r_s2;
        w_mul_b = COEF2;
      end
      default: ;
    endcase
  end

  assign w_prod     = 37'(w_mul_a) * 37'(w_mul_b);
  assign w_prod_ext = 40'(r_prod);
  assign w_c_ext    = 40'(r_c) <<< 17;
  assign w_acc_fin  = r_acc + w_prod_ext;
  assign w_shift    = w_acc_fin >>> 18;
  assign w_y_sat    = (w_shift > 40'sd131071)  ? 18'sd131071  :
                      (w_shift < -40'sd131072) ? -18'sd131072 : w_shift[17:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 11; i++) r_x[i] <= '0;
      r_phase   <= 1'b0;
      r_prod    <= '0;
      r_s1      <= '0;
      r_s2      <= '0;
      r_c       <= '0;
      r_acc     <= '0;
      r_y       <= '0;
      r_y_en    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_y_en <= 1'b0;
      if (bus.clk_en) begin
        r_x[0] <= bus.x_in;
        for (int i = 1; i < 11; i++) r_x[i] <= r_x[i-1];
        r_phase <= ~r_phase;
      end
      if (w_trig && w_busy) r_overrun <= 1'b1;
      // Pair sums and the centre sample are snapshotted so later shifts cannot disturb M1/M2.
      case (r_state)
        S_M0: begin
          r_prod <= w_prod;
          r_s1   <= 19'(r_x[2]) + 19'(r_x[8]);
          r_s2   <= 19'(r_x[4]) + 19'(r_x[6]);
          r_c    <= r_x[5];
        end
        S_M1: begin
          r_prod <= w_prod;
          r_acc  <= w_prod_ext + w_c_ext;
        end
        S_M2: begin
          r_prod <= w_prod;
          r_acc  <= r_acc + w_prod_ext;
        end
        S_FIN: begin
          r_y    <= w_y_sat;
          r_y_en <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.y       = r_y;
  assign bus.y_en    = r_y_en;
  assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_half_band_decimator_2.sv
// tb/tb_half_band_decimator_2.sv - directed bench with a per-cycle reference model of the decimator
module tb_half_band_decimator_2;
  logic clk;
  logic reset;
  half_band_decimator_2_if bus ();

  half_band_decimator_2 dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  // Reference: full-precision dot product of the window, decided per accepted trigger.
  localparam longint C0 = 1730;
  localparam longint C1 = -13369;
  localparam longint C2 = 77175;

  longint hist [0:10];
  int     phase    = 0;
  longint edge_n   = 0;
  longint last_acc = -100;
  longint pend_due [$];
  longint pend_val [$];
  longint exp_y    = 0;
  bit     exp_yen  = 0;
  bit     exp_ovr  = 0;

  function automatic longint model_y();
    longint acc;
    longint q;
    acc = C0 * (hist[0] + hist[10]) + C1 * (hist[2] + hist[8]) +
          C2 * (hist[4] + hist[6]) + hist[5] * 131072;
    q = acc >>> 18;
    if (q > 131071)  q = 131071;
    if (q < -131072) q = -131072;
    return q;
  endfunction

  always @(posedge clk) begin
    edge_n++;
    if (!reset) begin
      for (int i = 0; i < 11; i++) hist[i] = 0;
      phase = 0;
      last_acc = -100;
      pend_due.delete();
      pend_val.delete();
      exp_y = 0;
      exp_yen = 0;
      exp_ovr = 0;
    end else begin
      exp_yen = 0;
      if (pend_due.size() > 0 && pend_due[0] == edge_n) begin
        exp_y = pend_val.pop_front();
        void'(pend_due.pop_front());
        exp_yen = 1;
      end
      if (bus.clk_en) begin
        for (int i = 10; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = longint'(bus.x_in);
        if (phase == 1) begin
          if (edge_n - last_acc >= 4) begin
            last_acc = edge_n;
            pend_due.push_back(edge_n + 4);
            pend_val.push_back(model_y());
          end else begin
            exp_ovr = 1;
          end
        end
        phase ^= 1;
      end
    end
  end

  longint out_log [$];

  always @(negedge clk) begin
    if (check_en) begin
      check("y_en", longint'(bus.y_en), longint'(exp_yen));
      check("overrun", longint'(bus.overrun), longint'(exp_ovr));
      check("y", longint'(bus.y), exp_y);
      if (bus.y_en) out_log.push_back(longint'(bus.y));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input longint v);
    bus.clk_en = 1'b1;
    bus.x_in   = 18'(v);
    @(posedge clk);
    #2;
    bus.clk_en = 1'b0;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    out_log.delete();
  endtask

  task automatic check_out(input string name, input int idx, input longint exp);
    longint act;
    act = (idx < out_log.size()) ? out_log[idx] : 64'sd999999;
    check(name, act, exp);
  endtask

  longint imp2 [7] = '{432, -3343, 19293, 19293, -3343, 432, 0};
  longint imp1 [5] = '{0, 0, 32768, 0, 0};

  initial begin
    reset = 1'b0;
    bus.clk_en = 1'b0;
    bus.x_in = '0;
    @(posedge clk);
    #2;
    check_en = 1'b1;

    // Held in reset while samples arrive.
    for (int i = 0; i < 5; i++) push(5000);
    reset = 1'b1;
    check("rst_y", longint'(bus.y), 0);
    check("rst_y_en", longint'(bus.y_en), 0);
    check("rst_overrun", longint'(bus.overrun), 0);
    check("rst_outputs", out_log.size(), 0);

    // Impulse on sample 2 walks through the nonzero taps.
    do_reset();
    push(0);
    push(65536);
    for (int i = 0; i < 12; i++) push(0);
    idle(6);
    check("imp2_count", out_log.size(), 7);
    for (int i = 0; i < 7; i++) check_out($sformatf("imp2_y%0d", i), i, imp2[i]);

    // DC gain of one, positive and full-scale negative.
    do_reset();
    for (int i = 0; i < 14; i++) push(100000);
    idle(6);
    check_out("dc_pos_y5", 5, 100000);
    check_out("dc_pos_y6", 6, 100000);
    do_reset();
    for (int i = 0; i < 14; i++) push(-131072);
    idle(6);
    check_out("dc_neg_y5", 5, -131072);
    check_out("dc_neg_y6", 6, -131072);

    // Worst-case window saturates both ways (samples 4 and 10 land on x8 and x2).
    do_reset();
    for (int k = 1; k <= 12; k++) push((k == 4 || k == 10) ? -131072 : 131071);
    idle(6);
    check_out("sat_pos", 5, 131071);
    do_reset();
    for (int k = 1; k <= 12; k++) push((k == 4 || k == 10) ? 131071 : -131072);
    idle(6);
    check_out("sat_neg", 5, -131072);

    // Reset lands two clocks after a trigger: compute abandoned, y cleared.
    out_log.delete();
    push(65536);
    push(65536);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    check("midrst_y", longint'(bus.y), 0);
    idle(6);
    check("midrst_no_pulse", out_log.size(), 0);
    check("midrst_overrun", longint'(bus.overrun), 0);

    // FSM is back in IDLE: centre-tap impulse behaves normally without another reset.
    push(65536);
    for (int i = 0; i < 9; i++) push(0);
    idle(6);
    check("imp1_count", out_log.size(), 5);
    for (int i = 0; i < 5; i++) check_out($sformatf("imp1_y%0d", i), i, imp1[i]);

    // Strobe held high: every other trigger collides with a running compute.
    do_reset();
    check("cont_overrun_init", longint'(bus.overrun), 0);
    bus.clk_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.x_in = 18'((i * 7919) % 200000 - 100000);
      idle(1);
    end
    bus.clk_en = 1'b0;
    idle(8);
    check("cont_pulses", out_log.size(), 5);
    check("cont_overrun", longint'(bus.overrun), 1);

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
